// File: rtl/rv_dmem_responder.sv
// uRV data-memory responder: one load/store at a time, wait states, byte-enabled SRAM.
// Optional high-address range check enabled by defining RV_DM_RANGE_CHECK_EN.
module rv_dmem_responder #(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [31:0]           dm_addr_i,
  input  logic [31:0]           dm_data_s_i,
  input  logic [3:0]            dm_data_select_i,
  input  logic                  dm_store_i,
  input  logic                  dm_load_i,
  output logic                  dm_ready_o,
  output logic [31:0]           dm_data_l_o,
  output logic                  dm_load_done_o,
  output logic                  dm_err_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [31:0]           sram_data_o,
  input  logic [31:0]           sram_data_i,
  output logic [3:0]            sram_we_o,
  output logic                  sram_en_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t                state_q;
  logic [2:0]            cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            sel_q;
  logic                  store_q;
  logic                  flag_q;
  logic                  en_q;
  logic [3:0]            we_q;
  logic [ADDR_WIDTH-1:0] sram_addr_q;
  logic [31:0]           sram_data_q;
  logic                  done_q;
  logic                  err_q;
  logic [31:0]           ldata_q;

  logic                  accept;
  logic                  flag_in;
  logic                  go_acc;
  logic [ADDR_WIDTH-1:0] acc_addr_d;
  logic [31:0]           acc_data_d;
  logic [3:0]            acc_sel_d;
  logic                  acc_store_d;
  logic                  acc_flag_d;

  assign dm_ready_o = (state_q == S_IDLE) && rst_n_i;
  assign accept     = (dm_load_i | dm_store_i) && dm_ready_o;

`ifdef RV_DM_RANGE_CHECK_EN
  logic unused_addr;
  assign unused_addr = ^dm_addr_i[1:0];
  assign flag_in     = |dm_addr_i[31:ADDR_WIDTH+2];
  assign dm_err_o    = err_q;
`else
  logic unused_addr;
  assign unused_addr = ^{dm_addr_i[31:ADDR_WIDTH+2], dm_addr_i[1:0], err_q};
  assign flag_in     = 1'b0;
  assign dm_err_o    = 1'b0;
`endif

  // Zero-wait requests go straight from IDLE to ACCESS, so take live inputs there.
  assign go_acc = (state_q == S_IDLE && accept && WAIT_STATES == 0)
               || (state_q == S_WAIT && cnt_q == 3'd0);
  assign acc_addr_d  = (state_q == S_IDLE) ? dm_addr_i[ADDR_WIDTH+1:2] : addr_q;
  assign acc_data_d  = (state_q == S_IDLE) ? dm_data_s_i : wdata_q;
  assign acc_sel_d   = (state_q == S_IDLE) ? dm_data_select_i : sel_q;
  assign acc_store_d = (state_q == S_IDLE) ? dm_store_i : store_q;
  assign acc_flag_d  = (state_q == S_IDLE) ? flag_in : flag_q;

  // The load word bypasses the holding register in the completion cycle.
  assign dm_data_l_o    = done_q ? (flag_q ? 32'h0 : sram_data_i) : ldata_q;
  assign dm_load_done_o = done_q;
  assign sram_en_o      = en_q;
  assign sram_we_o      = we_q;
  assign sram_addr_o    = sram_addr_q;
  assign sram_data_o    = sram_data_q;

  // Request FSM with registered SRAM strobes and response pulses.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      sel_q       <= 4'h0;
      store_q     <= 1'b0;
      flag_q      <= 1'b0;
      en_q        <= 1'b0;
      we_q        <= 4'h0;
      sram_addr_q <= '0;
      sram_data_q <= 32'h0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ldata_q     <= 32'h0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      en_q   <= 1'b0;
      we_q   <= 4'h0;
      if (go_acc) begin
        en_q        <= ~acc_flag_d;
        we_q        <= (acc_store_d && !acc_flag_d) ? acc_sel_d : 4'h0;
        sram_addr_q <= acc_addr_d;
        sram_data_q <= acc_data_d;
      end
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            addr_q  <= dm_addr_i[ADDR_WIDTH+1:2];
            wdata_q <= dm_data_s_i;
            sel_q   <= dm_data_select_i;
            store_q <= dm_store_i;
            flag_q  <= flag_in;
            if (WAIT_STATES == 0) begin
              state_q <= S_ACCESS;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= 3'(WAIT_STATES - 1);
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 3'd0) state_q <= S_ACCESS;
          else cnt_q <= cnt_q - 3'd1;
        end
        S_ACCESS: begin
          state_q <= S_RESP;
          done_q  <= ~store_q;
          err_q   <= flag_q;
        end
        S_RESP: begin
          state_q <= S_IDLE;
          if (!store_q) ldata_q <= flag_q ? 32'h0 : sram_data_i;
        end
      endcase
    end
  end

endmodule
